// File: rtl/bsg_relay_narrow.sv
// rtl/bsg_relay_narrow.sv - width-narrowing valid/ready source stage for relay FIFO chains
// Optional last_o output enabled by defining BSG_RELAY_NARROW_LAST_EN.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module bsg_relay_narrow #(
    parameter int width_p      = 32,
    parameter int els_p        = 2,
    parameter bit lsb_to_msb_p = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    output logic                       ready_o,
    input  logic [width_p-1:0]         data_i,
    input  logic                       v_i,
    output logic                       v_o,
    output logic [width_p/els_p-1:0]   data_o,
    input  logic                       ready_i
`ifdef BSG_RELAY_NARROW_LAST_EN
    , output logic                     last_o
`endif
);

    localparam int flit_w = width_p / els_p;
    localparam int cnt_w  = `BSG_SAFE_CLOG2(els_p);

    if (els_p < 1) begin : g_els_err
        $error("bsg_relay_narrow: els_p must be at least 1");
    end else if ((width_p % els_p) != 0) begin : g_width_err
        $error("bsg_relay_narrow: width_p must be a multiple of els_p");
    end

    logic [width_p-1:0] data_r;
    logic [cnt_w-1:0]   cnt_r;
    logic               full_r;
    logic [cnt_w-1:0]   sel;
    logic               last;

    assign last    = (cnt_r == cnt_w'(els_p - 1));
    assign v_o     = full_r;
    assign ready_o = reset_n_i & (~full_r | (ready_i & last));

`ifdef BSG_RELAY_NARROW_LAST_EN
    assign last_o = full_r & last;
`endif

    always_comb begin
        sel = cnt_r;
        if (!lsb_to_msb_p) begin
            sel = cnt_w'(els_p - 1) - cnt_r;
        end
        data_o = data_r[int'(sel) * flit_w +: flit_w];
    end

    // A word accepted on the same edge as the last flit departs overrides the clear.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            full_r <= 1'b0;
            cnt_r  <= '0;
            data_r <= '0;
        end else begin
            if (full_r && ready_i) begin
                if (last) begin
                    cnt_r  <= '0;
                    full_r <= 1'b0;
                end else begin
                    cnt_r <= cnt_r + cnt_w'(1);
                end
            end
            if (v_i && ready_o) begin
                data_r <= data_i;
                full_r <= 1'b1;
                cnt_r  <= '0;
            end
        end
    end

endmodule
